// File: rtl/lut_pkg.sv
// Shared definitions for the configurable LUT block.
// Holds the upper bound on LUT inputs, the configuration FSM state type
// and a helper that converts an input count into a truth-table width.
package lut_pkg;

  localparam int unsigned K_MAX = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } lut_state_e;

  function automatic int unsigned tbl_bits(input int unsigned k);
    return 32'd1 << k;
  endfunction

endpackage

// File: rtl/lut_cfg_shreg.sv
// Shadow table shift register and accepted-bit counter for lut_cfg.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (clears shadow and count)
//   clr        - discard shadow contents and zero the count
//   shift      - shift bit_in into the shadow LSB and bump the count
//   bit_in     - serial table bit
//   shadow     - 2^K-bit shadow table (first bit shifted in ends up at the MSB)
//   count      - number of bits accepted since the last clear (K+1 bits)
module lut_cfg_shreg #(
  parameter int unsigned K = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                shift,
  input  logic                bit_in,
  output logic [(1<<K)-1:0]   shadow,
  output logic [K:0]          count
);

  localparam int unsigned N = 1 << K;
  localparam logic [K:0]  ONE = {{K{1'b0}}, 1'b1};

  logic [N-1:0] shadow_q, shadow_d;
  logic [K:0]   count_q, count_d;

  // Clear is applied before the shift so a bit arriving together with a
  // clear becomes the first bit of the fresh load.
  always_comb begin
    shadow_d = shadow_q;
    count_d  = count_q;
    if (clr) begin
      shadow_d = '0;
      count_d  = '0;
    end
    if (shift) begin
      shadow_d = {shadow_d[N-2:0], bit_in};
      count_d  = count_d + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      count_q  <= '0;
    end else begin
      shadow_q <= shadow_d;
      count_q  <= count_d;
    end
  end

  assign shadow = shadow_q;
  assign count  = count_q;

endmodule

// File: rtl/lut_cfg.sv
// Runtime-reconfigurable K-input LUT with a serially loaded shadow table.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   i_in       - LUT select inputs, bit 0 is the table index LSB
//   cfg_start  - begin (or restart) a table reload
//   cfg_valid  - cfg_bit is valid this cycle
//   cfg_bit    - serial table bit, highest index first
//   cfg_ready  - bits are being accepted this cycle
//   cfg_done   - one-cycle pulse after a new table has been committed
//   o6         - TBL[i_in]
//   o5         - TBL[{0, i_in[K-2:0]}] (lower half table)
module lut_cfg
  import lut_pkg::*;
#(
  parameter int unsigned       K       = 6,
  parameter logic [(1<<K)-1:0] INIT    = '0,
  parameter bit                OUT_REG = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [K-1:0] i_in,
  input  logic         cfg_start,
  input  logic         cfg_valid,
  input  logic         cfg_bit,
  output logic         cfg_ready,
  output logic         cfg_done,
  output logic         o6,
  output logic         o5
);

  localparam int unsigned N        = tbl_bits(K);
  localparam logic [K:0]  LAST_CNT = {1'b0, {K{1'b1}}};

  if (K < 2 || K > K_MAX) begin : g_bad_k
    $error("lut_cfg: K out of range");
  end

  lut_state_e   state_q, state_d;
  logic [N-1:0] tbl_q, tbl_d;
  logic         cfg_ready_q, cfg_ready_d;
  logic         cfg_done_q, cfg_done_d;

  logic         sh_clr, sh_shift;
  logic [N-1:0] sh_shadow;
  logic [K:0]   sh_count;

  lut_cfg_shreg #(.K(K)) u_shreg (
    .clk    (clk),
    .rst    (rst),
    .clr    (sh_clr),
    .shift  (sh_shift),
    .bit_in (cfg_bit),
    .shadow (sh_shadow),
    .count  (sh_count)
  );

  // cfg_ready/cfg_done are registered, so they are computed for the state
  // being entered rather than the current one.
  always_comb begin
    state_d     = state_q;
    tbl_d       = tbl_q;
    cfg_ready_d = 1'b0;
    cfg_done_d  = 1'b0;
    sh_clr      = 1'b0;
    sh_shift    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          sh_clr      = 1'b1;
          state_d     = ST_SHIFT;
          cfg_ready_d = 1'b1;
        end
      end
      ST_SHIFT: begin
        sh_clr      = cfg_start;
        sh_shift    = cfg_valid;
        cfg_ready_d = 1'b1;
        // A restart with a bit in the same cycle only ever holds one bit.
        if (cfg_valid && !cfg_start && sh_count == LAST_CNT) begin
          state_d     = ST_COMMIT;
          cfg_ready_d = 1'b0;
        end
      end
      ST_COMMIT: begin
        tbl_d      = sh_shadow;
        cfg_done_d = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tbl_q       <= INIT;
      cfg_ready_q <= 1'b0;
      cfg_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tbl_q       <= tbl_d;
      cfg_ready_q <= cfg_ready_d;
      cfg_done_q  <= cfg_done_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign cfg_done  = cfg_done_q;

  if (OUT_REG) begin : g_reg
    logic o6_q, o6_d, o5_q, o5_d;

    always_comb begin
      o6_d = tbl_q[i_in];
      o5_d = tbl_q[{1'b0, i_in[K-2:0]}];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        o6_q <= 1'b0;
        o5_q <= 1'b0;
      end else begin
        o6_q <= o6_d;
        o5_q <= o5_d;
      end
    end

    assign o6 = o6_q;
    assign o5 = o5_q;
  end else begin : g_comb
    assign o6 = tbl_q[i_in];
    assign o5 = tbl_q[{1'b0, i_in[K-2:0]}];
  end

endmodule

// File: tb/tb_lut_cfg.sv
module tb_lut_cfg;

  localparam logic [63:0] INIT_A = 64'h8000_0000_0000_0001;
  localparam logic [15:0] INIT_B = 16'hCA00;

  logic clk = 1'b0;
  logic rst;

  // DUT A: K=6, registered outputs
  logic [5:0] a_i;
  logic a_start, a_valid, a_bit, a_ready, a_done, a_o6, a_o5;
  // DUT B: K=4, combinational outputs
  logic [3:0] b_i;
  logic b_start, b_valid, b_bit, b_ready, b_done, b_o6, b_o5;

  lut_cfg #(.K(6), .INIT(INIT_A), .OUT_REG(1'b1)) dut_a (
    .clk(clk), .rst(rst), .i_in(a_i), .cfg_start(a_start), .cfg_valid(a_valid),
    .cfg_bit(a_bit), .cfg_ready(a_ready), .cfg_done(a_done), .o6(a_o6), .o5(a_o5)
  );

  lut_cfg #(.K(4), .INIT(INIT_B), .OUT_REG(1'b0)) dut_b (
    .clk(clk), .rst(rst), .i_in(b_i), .cfg_start(b_start), .cfg_valid(b_valid),
    .cfg_bit(b_bit), .cfg_ready(b_ready), .cfg_done(b_done), .o6(b_o6), .o5(b_o5)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  // Reference truth tables: [0] for A (64 bits), [1] for B (low 16 bits)
  logic [63:0] mtbl [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int nbits(input int w);
    return (w == 0) ? 64 : 16;
  endfunction

  function automatic logic m_o6(input int w, input int idx);
    return mtbl[w][idx];
  endfunction

  function automatic logic m_o5(input int w, input int idx);
    return mtbl[w][idx % (nbits(w) / 2)];
  endfunction

  function automatic logic get_ready(input int w);
    return (w == 0) ? a_ready : b_ready;
  endfunction

  function automatic logic get_done(input int w);
    return (w == 0) ? a_done : b_done;
  endfunction

  function automatic logic get_o6(input int w);
    return (w == 0) ? a_o6 : b_o6;
  endfunction

  function automatic logic get_o5(input int w);
    return (w == 0) ? a_o5 : b_o5;
  endfunction

  task automatic set_cfg(input int w, input logic s, input logic v, input logic b);
    if (w == 0) begin
      a_start = s; a_valid = v; a_bit = b;
    end else begin
      b_start = s; b_valid = v; b_bit = b;
    end
  endtask

  task automatic set_idx(input int w, input int idx);
    if (w == 0) a_i = 6'(idx);
    else        b_i = 4'(idx);
  endtask

  // Registered outputs appear one edge after i_in; combinational ones settle at once.
  task automatic lookup(input int w, input int idx, input string tag);
    set_idx(w, idx);
    if (w == 0) tick();
    else #1;
    check($sformatf("%s_o6[%0d]", tag, idx), 64'(get_o6(w)), 64'(m_o6(w, idx)));
    check($sformatf("%s_o5[%0d]", tag, idx), 64'(get_o5(w)), 64'(m_o5(w, idx)));
  endtask

  task automatic sweep(input int w, input string tag);
    for (int idx = 0; idx < nbits(w); idx++) lookup(w, idx, tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_cfg(0, 1'b0, 1'b0, 1'b0);
    set_cfg(1, 1'b0, 1'b0, 1'b0);
    tick();
    check("rst_a_o6", 64'(a_o6), 64'd0);
    check("rst_a_o5", 64'(a_o5), 64'd0);
    check("rst_a_ready", 64'(a_ready), 64'd0);
    check("rst_a_done", 64'(a_done), 64'd0);
    check("rst_b_ready", 64'(b_ready), 64'd0);
    check("rst_b_done", 64'(b_done), 64'd0);
    mtbl[0] = INIT_A;
    mtbl[1] = {48'd0, INIT_B};
    check("rst_b_o6", 64'(b_o6), 64'(m_o6(1, int'(b_i))));
    rst = 1'b0;
  endtask

  // One table load. gap = idle cycles between consecutive bits; restart_at > 0
  // sends that many junk bits first and then restarts with cfg_start and the
  // first real bit in the same cycle. exp_lat (if > 0) is the expected number
  // of cycles from the cfg_start cycle to the cycle cfg_done is seen.
  task automatic load(input int w, input logic [63:0] word, input int gap,
                      input int restart_at, input bit start_in_commit, input int exp_lat);
    int n, probe, t_start, t_last, t_done;
    logic old6, new6;
    bit seen;
    n     = nbits(w);
    probe = $urandom_range(0, n - 1);
    old6  = mtbl[w][probe];
    new6  = word[probe];
    seen  = 1'b0;
    t_last = 0;
    t_done = 0;
    set_idx(w, probe);
    set_cfg(w, 1'b1, 1'b0, 1'b0);
    t_start = cyc;
    tick();
    set_cfg(w, 1'b0, 1'b0, 1'b0);
    check("ld_ready_shift", 64'(get_ready(w)), 64'd1);
    for (int j = 0; j < restart_at; j++) begin
      set_cfg(w, 1'b0, 1'b1, 1'($urandom));
      tick();
    end
    for (int i = n - 1; i >= 0; i--) begin
      if (i != n - 1) begin
        for (int g = 0; g < gap; g++) begin
          set_cfg(w, 1'b0, 1'b0, 1'($urandom));
          tick();
        end
      end
      set_cfg(w, (restart_at > 0 && i == n - 1), 1'b1, word[i]);
      t_last = cyc;
      tick();
      if (i % 16 == 5) check("ld_old_held_o6", 64'(get_o6(w)), 64'(old6));
    end
    // commit cycle: any cfg_start here must be ignored
    set_cfg(w, start_in_commit, 1'b0, 1'b0);
    check("ld_commit_ready", 64'(get_ready(w)), 64'd0);
    check("ld_commit_done", 64'(get_done(w)), 64'd0);
    tick();
    set_cfg(w, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8 && !seen; k++) begin
      if (get_done(w)) begin
        seen   = 1'b1;
        t_done = cyc;
      end else begin
        tick();
      end
    end
    check("ld_done_seen", 64'(seen), 64'd1);
    if (seen) begin
      check("ld_done_after_last_bit", 64'(t_done - t_last), 64'd2);
      if (exp_lat > 0) check("ld_latency", 64'(t_done - t_start), 64'(exp_lat));
      check("ld_ready_after", 64'(get_ready(w)), 64'd0);
      // registered outputs still show the old table in the done cycle
      check("ld_o6_done_cycle", 64'(get_o6(w)), 64'((w == 0) ? old6 : new6));
    end
    mtbl[w] = word;
    tick();
    check("ld_done_single", 64'(get_done(w)), 64'd0);
    check("ld_ready_idle", 64'(get_ready(w)), 64'd0);
    check("ld_o6_new", 64'(get_o6(w)), 64'(new6));
  endtask

  initial begin
    logic [63:0] word;
    int done_cnt;
    rst = 1'b1;
    a_i = '0;
    b_i = '0;
    set_cfg(0, 1'b0, 1'b0, 1'b0);
    set_cfg(1, 1'b0, 1'b0, 1'b0);
    tick();
    do_reset();

    // power-up tables
    lookup(0, 0, "initA");
    lookup(0, 63, "initA");
    lookup(1, 15, "initB");
    lookup(1, 7, "initB");
    for (int r = 0; r < 6; r++) lookup(1, $urandom_range(0, 15), "initB_rnd");

    // continuous load on A
    load(0, 64'hFFFF_FFFF_0000_0000, 0, 0, 1'b0, 66);
    lookup(0, 32, "loadA");
    sweep(0, "loadA_sweep");

    // same load with cfg_valid toggling: 64 bits spread over 127 cycles
    do_reset();
    load(0, 64'hFFFF_FFFF_0000_0000, 1, 0, 1'b0, 1 + 127 + 1);
    lookup(0, 32, "togA");

    // restart after 10 bits, then a full load of 1
    load(0, 64'h0000_0000_0000_0001, 0, 10, 1'b0, 0);
    lookup(0, 0, "rstrtA");
    sweep(0, "rstrtA_sweep");

    // randomized loads with cfg_start asserted during commit
    for (int r = 0; r < 4; r++) begin
      int w;
      w = r % 2;
      word = {$urandom, $urandom};
      if (w == 1) word = {48'd0, word[15:0]};
      load(w, word, $urandom_range(0, 2), (r == 2) ? int'($urandom_range(1, 12)) : 0, 1'b1, 0);
      sweep(w, "rndld");
    end

    // reset in the middle of a load on A
    set_idx(0, 0);
    set_cfg(0, 1'b1, 1'b0, 1'b0);
    tick();
    for (int j = 0; j < 40; j++) begin
      set_cfg(0, 1'b0, 1'b1, 1'($urandom));
      tick();
    end
    rst = 1'b1;
    set_cfg(0, 1'b0, 1'b1, 1'b1);
    tick();
    rst = 1'b0;
    mtbl[0] = INIT_A;
    mtbl[1] = {48'd0, INIT_B};
    check("abort_o6_zero", 64'(a_o6), 64'd0);
    check("abort_ready", 64'(a_ready), 64'd0);
    done_cnt = 0;
    for (int j = 0; j < 30; j++) begin
      set_cfg(0, 1'b0, 1'b1, 1'($urandom));
      tick();
      if (a_done) done_cnt++;
    end
    set_cfg(0, 1'b0, 1'b0, 1'b0);
    check("abort_no_done", 64'(done_cnt), 64'd0);
    check("abort_ready_idle", 64'(a_ready), 64'd0);
    sweep(0, "abortA_sweep");
    sweep(1, "abortB_sweep");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=%0d exp=%0d", cyc, 0);
    $fatal(1, "timeout");
  end

endmodule
